alu_cmd_sequencer: RTL and testbench

Command-side counterpart of the 2-bit ALU. It takes ALU commands as two 4-bit beats over a valid/ready input and drives the ALU operand and select lines. After a fixed settle time it captures ALU_Out and CarryOut and holds the result until the consumer acknowledges it. It sits between the tile I/O pins and the ALU, so the ALU can be exercised on silicon without a testbench.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_cmd_sequencer_if.sv | 24 ++
 rtl/alu_seq_settle_timer.sv | 34 +++
 rtl/alu_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and field positions for the ALU command sequencer.
// Holds the FSM state enum, bus widths and beat1 operand bit positions.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_SEL,
        S_OPS,
        S_WAIT,
        S_RESULT
    } state_t;

    localparam int OPW  = 2;
    localparam int SELW = 4;
    localparam int OUTW = 7;

    localparam int A_HI = 3;
    localparam int A_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/result handshake bundle between the pins and the sequencer.
// Ports: in_valid/in_ready/in_data beats, res_valid/res_ack/res_data/res_carry.
interface alu_cmd_sequencer_if;
    import alu_seq_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [SELW-1:0] in_data;
    logic            res_valid;
    logic            res_ack;
    logic [OUTW-1:0] res_data;
    logic            res_carry;

    modport master (
        output in_valid, in_data, res_ack,
        input  in_ready, res_valid, res_data, res_carry
    );

    modport slave (
        input  in_valid, in_data, res_ack,
        output in_ready, res_valid, res_data, res_carry
    );

endinterface

// File: rtl/alu_seq_settle_timer.sv
// Down-counter timing the ALU settle window after operands are driven.
// Ports: clk, reset, load, load_val[3:0] in; expired (one-cycle pulse) out.
module alu_seq_settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expired
);

    logic [3:0] cnt;
    logic       armed;

    // armed keeps expired to a single pulse per load, even when the
    // load value is zero and the count starts out already at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == 4'd0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign expired = armed && (cnt == 4'd0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Two-beat command sequencer that drives the ALU and captures its result.
// Ports: clk, reset, bus (slave handshake), alu_a/b/sel out, alu_out/carry in, cmd_count out.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_cmd_sequencer_if.slave   bus,
    output logic [OPW-1:0]       alu_a,
    output logic [OPW-1:0]       alu_b,
    output logic [SELW-1:0]      alu_sel,
    input  logic [OUTW-1:0]      alu_out,
    input  logic                 alu_carry,
    output logic [CNT_W-1:0]     cmd_count
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

    state_t state;
    state_t state_n;

    logic [SELW-1:0] sel_q;
    logic [OUTW-1:0] res_data_q;
    logic            res_carry_q;
    logic            res_valid_q;

    logic rdy;
    logic beat;
    logic sel_ld;
    logic ops_ld;
    logic cap;
    logic done;
    logic expired;

    assign rdy  = (state == S_SEL) || (state == S_OPS);
    assign beat = bus.in_valid && rdy;

    assign bus.in_ready  = rdy;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;

    alu_seq_settle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ops_ld),
        .load_val (SETTLE_LD),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SEL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_ld  = 1'b0;
        ops_ld  = 1'b0;
        cap     = 1'b0;
        done    = 1'b0;
        case (state)
            S_SEL: begin
                if (beat) begin
                    sel_ld  = 1'b1;
                    state_n = S_OPS;
                end
            end
            S_OPS: begin
                if (beat) begin
                    ops_ld  = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (expired) begin
                    cap     = 1'b1;
                    state_n = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.res_ack) begin
                    done    = 1'b1;
                    state_n = S_SEL;
                end
            end
            default: state_n = S_SEL;
        endcase
    end

    // Select is staged in sel_q so alu_sel/a/b all change on the same
    // edge: the ALU never sees a new select with stale operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= '0;
            alu_sel     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_valid_q <= 1'b0;
            cmd_count   <= '0;
        end else begin
            if (sel_ld) begin
                sel_q <= bus.in_data;
            end
            if (ops_ld) begin
                alu_sel <= sel_q;
                alu_a   <= bus.in_data[A_HI:A_LO];
                alu_b   <= bus.in_data[B_HI:B_LO];
            end
            if (cap) begin
                res_data_q  <= alu_out;
                res_carry_q <= alu_carry;
                res_valid_q <= 1'b1;
            end
            if (done) begin
                res_valid_q <= 1'b0;
                cmd_count   <= cmd_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a stub ALU.
// Table vectors, hand-written corner sequences and randomized commands.
module tb_alu_cmd_sequencer;

    localparam int SETTLE = 2;
    localparam int CW     = 4;

    logic       clk;
    logic       reset;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [3:0] alu_sel;
    logic [6:0] alu_out;
    logic       alu_carry;
    logic [CW-1:0] cmd_count;

    alu_cmd_sequencer_if ifc ();

    alu_cmd_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .cmd_count (cmd_count)
    );

    assign alu_out   = {alu_sel[2:0], alu_a, alu_b};
    assign alu_carry = alu_sel[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [1:0] a;
        logic [1:0] b;
        logic [6:0] exp_data;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[5];

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected ALU stub result from the operands: sel low bits, A, B.
    function automatic logic [6:0] ref_data(input logic [3:0] s,
                                            input logic [1:0] a,
                                            input logic [1:0] b);
        int v;
        v = (int'(s) % 8) * 16 + int'(a) * 4 + int'(b);
        return 7'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] d);
        logic rdy;
        int   n;
        n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        do begin
            rdy = ifc.in_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        ifc.in_valid = 1'b0;
        if (!rdy) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic finish_cmd(input logic [3:0] s, input logic [1:0] a,
                              input logic [1:0] b, input logic [6:0] ed,
                              input logic ec, input int ack_dly);
        int n;
        send_beat({a, b});
        chk("alu_sel", alu_sel, s);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        n = 0;
        while (!ifc.res_valid && n < 20) begin
            tick();
            n++;
        end
        chk("settle_edges", n, SETTLE);
        chk("res_data", ifc.res_data, ed);
        chk("res_carry", ifc.res_carry, ec);
        repeat (ack_dly) tick();
        chk("res_valid_held", ifc.res_valid, 1);
        ifc.res_ack = 1'b1;
        tick();
        ifc.res_ack = 1'b0;
        model_cnt = (model_cnt + 1) % (1 << CW);
        chk("res_valid_after_ack", ifc.res_valid, 0);
        chk("cmd_count", cmd_count, model_cnt);
    endtask

    task automatic run_cmd(input logic [3:0] s, input logic [1:0] a,
                           input logic [1:0] b, input logic [6:0] ed,
                           input logic ec, input int ack_dly);
        send_beat(s);
        finish_cmd(s, a, b, ed, ec, ack_dly);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1011, 2'b10, 2'b01, 7'b0111001, 1'b1};
        vecs[1] = '{4'b0001, 2'b11, 2'b10, 7'b0011110, 1'b0};
        vecs[2] = '{4'b1111, 2'b11, 2'b11, 7'b1111111, 1'b1};
        vecs[3] = '{4'b0100, 2'b00, 2'b11, 7'b1000011, 1'b0};
        vecs[4] = '{4'b1000, 2'b01, 2'b00, 7'b0000100, 1'b1};

        reset        = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.res_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_res_valid", ifc.res_valid, 0);
        chk("rst_res_data", ifc.res_data, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_in_ready", ifc.in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i].sel, vecs[i].a, vecs[i].b,
                    vecs[i].exp_data, vecs[i].exp_carry, i);
        end

        // Held result with stray in_valid pulses that must not be taken.
        send_beat(4'b0001);
        send_beat(4'b1110);
        repeat (SETTLE) tick();
        for (int i = 0; i < 10; i++) begin
            ifc.in_valid = (i % 2 == 0);
            ifc.in_data  = 4'hf;
            tick();
            chk("hold_res_valid", ifc.res_valid, 1);
            chk("hold_res_data", ifc.res_data, 7'b0011110);
            chk("hold_in_ready", ifc.in_ready, 0);
            chk("hold_alu_sel", alu_sel, 4'b0001);
        end
        ifc.in_valid = 1'b0;
        ifc.res_ack  = 1'b1;
        tick();
        ifc.res_ack = 1'b0;
        model_cnt++;
        chk("hold_cmd_count", cmd_count, model_cnt);
        run_cmd(4'b0110, 2'b01, 2'b10, 7'b1100110, 1'b0, 0);

        // Stall between beats with stray acks.
        send_beat(4'b1101);
        for (int i = 0; i < 5; i++) begin
            ifc.res_ack = (i % 2 == 0);
            tick();
            chk("stall_in_ready", ifc.in_ready, 1);
            chk("stall_res_valid", ifc.res_valid, 0);
            chk("stall_cmd_count", cmd_count, model_cnt);
        end
        ifc.res_ack = 1'b0;
        finish_cmd(4'b1101, 2'b00, 2'b11, 7'b1010011, 1'b1, 1);

        // Reset while waiting for the ALU to settle.
        send_beat(4'b1111);
        send_beat(4'b1111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_cnt = 0;
        chk("mid_rst_res_valid", ifc.res_valid, 0);
        chk("mid_rst_alu", {alu_sel, alu_a, alu_b}, 0);
        chk("mid_rst_cmd_count", cmd_count, 0);
        chk("mid_rst_in_ready", ifc.in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_rst_no_capture", {ifc.res_valid, ifc.res_data}, 0);
        end

        // Counter wrap.
        for (int i = 1; i <= 16; i++) begin
            run_cmd(4'b0000, 2'b00, 2'b00, 7'b0000000, 1'b0, 0);
            if (i == 15) chk("wrap_15", cmd_count, 15);
            if (i == 16) chk("wrap_0", cmd_count, 0);
        end

        // Randomized commands.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] s;
            logic [1:0] a;
            logic [1:0] b;
            s = 4'($urandom);
            a = 2'($urandom);
            b = 2'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            run_cmd(s, a, b, ref_data(s, a, b), s[3],
                    int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
